// File: rtl/pixel_capture.sv
// Camera byte-stream front end: frames bytes with vsync/href, packs RGB565 pixels,
// tags SOF/EOL and buffers them in a show-ahead FIFO with a valid/ready handshake.
module pixel_capture #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_valid,
  input  logic [7:0]  cam_data,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] frame_cnt,
  output logic        ovf,
  output logic        fmt_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [11:0]   XY_SAT  = 12'hFFF;
  localparam logic [11:0]   W_END   = 12'(WIDTH);
  localparam logic [11:0]   W_LAST  = 12'(WIDTH - 1);
  localparam logic [11:0]   H_END   = 12'(HEIGHT);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2,
    SKIP   = 2'd3
  } state_t;

  state_t         state_r, state_next_s;
  logic           href_d_r;
  logic           phase_r;
  logic [7:0]     hi_r;
  logic [11:0]    x_r, y_r;
  logic [17:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]  count_r, count_next_s;

  logic take_s, eol_evt_s, eof_s, push_req_s, push_s, pop_s, full_s, drop_s;
  logic sof_tag_s, eol_tag_s;

  // Frame state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= SYNC;
    else     state_r <= state_next_s;
  end

  // Next-state logic; SYNC waits for a full blank so a frame in progress at reset is never captured
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SYNC: begin
        if (cam_vsync) state_next_s = VBLANK;
        else           state_next_s = SYNC;
      end
      VBLANK: begin
        if (!cam_vsync) state_next_s = cap_en ? ACTIVE : SKIP;
        else            state_next_s = VBLANK;
      end
      ACTIVE: begin
        if (cam_vsync) state_next_s = VBLANK;
        else           state_next_s = ACTIVE;
      end
      SKIP: begin
        if (cam_vsync) state_next_s = VBLANK;
        else           state_next_s = SKIP;
      end
      default: state_next_s = SYNC;
    endcase
  end

  // Capture-side events and FIFO handshake decode
  always_comb begin
    take_s     = (state_r == ACTIVE) && cam_valid && cam_href;
    eof_s      = (state_r == ACTIVE) && cam_vsync;
    eol_evt_s  = (state_r == ACTIVE) && !cam_vsync && href_d_r && !cam_href;
    push_req_s = take_s && phase_r;
    pop_s      = pix_valid && pix_ready;
    full_s     = (count_r == DEPTH_C);
    push_s     = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
    sof_tag_s  = (x_r == 12'd0) && (y_r == 12'd0);
    eol_tag_s  = (x_r == W_LAST);
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Byte packing, line/frame position tracking and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_d_r  <= 1'b0;
      phase_r   <= 1'b0;
      hi_r      <= 8'd0;
      x_r       <= 12'd0;
      y_r       <= 12'd0;
      frame_cnt <= 16'd0;
      ovf       <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      href_d_r <= cam_href;
      if (eof_s) begin
        frame_cnt <= frame_cnt + 16'd1;
        if (y_r != H_END) fmt_err <= 1'b1;
        x_r     <= 12'd0;
        y_r     <= 12'd0;
        phase_r <= 1'b0;
      end else if (eol_evt_s) begin
        // a dangling high byte is discarded and flagged as a short line
        if ((x_r != W_END) || phase_r) fmt_err <= 1'b1;
        x_r     <= 12'd0;
        phase_r <= 1'b0;
        if (y_r != XY_SAT) y_r <= y_r + 12'd1;
      end else if (take_s) begin
        if (!phase_r) begin
          hi_r    <= cam_data;
          phase_r <= 1'b1;
        end else begin
          phase_r <= 1'b0;
          if (x_r != XY_SAT) x_r <= x_r + 12'd1;
        end
      end
      if (drop_s) ovf <= 1'b1;
    end
  end

  // Show-ahead pixel FIFO; storage is cleared on reset so the head reads 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      pix_valid <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 18'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {sof_tag_s, eol_tag_s, hi_r, cam_data};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r   <= count_next_s;
      pix_valid <= (count_next_s != '0);
    end
  end

  assign {pix_sof, pix_eol, pix_data} = mem_r[rd_ptr_r];

endmodule

// File: tb/tb_pixel_capture.sv
// Directed bench for pixel_capture (WIDTH=4, HEIGHT=2, FIFO_DEPTH=4) with hand-computed pixels.
module tb_pixel_capture;
  logic        clk, rst, cap_en, cam_vsync, cam_href, cam_valid, pix_ready;
  logic [7:0]  cam_data;
  logic [15:0] pix_data, frame_cnt;
  logic        pix_sof, pix_eol, pix_valid, ovf, fmt_err;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int v0, qb;
  logic [17:0] q[$];

  pixel_capture #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_valid(cam_valid), .cam_data(cam_data),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_cnt(frame_cnt),
    .ovf(ovf), .fmt_err(fmt_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record accepted pixels and valid cycles mid-period, away from the active edge
  always @(negedge clk) begin
    if (pix_valid && pix_ready) q.push_back({pix_sof, pix_eol, pix_data});
    if (pix_valid) valid_cnt <= valid_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] px(input logic sof, input logic eol, input logic [7:0] hi);
    logic [7:0] lo;
    lo = hi + 8'd1;
    return {sof, eol, hi, lo};
  endfunction

  task automatic check_pix(input string tag, input int idx, input logic [17:0] exp);
    if (qb + idx < q.size()) check_val(tag, 32'(q[qb + idx]), 32'(exp));
    else                     check_val(tag, 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_start(input logic en);
    cap_en    = en;
    cam_vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    repeat (3) tick();
  endtask

  task automatic send_line(input logic [7:0] base, input int nbytes);
    cam_href = 1'b1;
    tick();
    for (int i = 0; i < nbytes; i++) begin
      cam_valid = 1'b1;
      cam_data  = base + 8'(i);
      tick();
    end
    cam_valid = 1'b0;
    cam_href  = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; cap_en = 1'b1; cam_vsync = 1'b0; cam_href = 1'b1;
    cam_valid = 1'b0; cam_data = 8'd0; pix_ready = 1'b1;
    repeat (3) tick();
    check_val("rst_valid", 32'(pix_valid), 32'd0);
    check_val("rst_data", 32'(pix_data), 32'd0);
    check_val("rst_tags", 32'({pix_sof, pix_eol}), 32'd0);
    check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check_val("rst_flags", 32'({ovf, fmt_err}), 32'd0);

    // Reset released in the middle of a streaming frame
    v0 = valid_cnt;
    qb = q.size();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cam_valid = 1'b1;
      cam_data  = 8'(8'h80 + i);
      tick();
    end
    cam_valid = 1'b0;
    send_line(8'h90, 8);
    frame_end();
    check_val("t1_no_valid", 32'(valid_cnt - v0), 32'd0);
    check_val("t1_no_pixels", 32'(q.size() - qb), 32'd0);
    check_val("t1_frame_cnt", 32'(frame_cnt), 32'd0);

    // Clean 4x2 frame, bytes 00..0F
    qb = q.size();
    frame_start(1'b1);
    send_line(8'h00, 8);
    send_line(8'h08, 8);
    frame_end();
    repeat (4) tick();
    check_val("t2_count", 32'(q.size() - qb), 32'd8);
    for (int i = 0; i < 8; i++)
      check_pix($sformatf("t2_pix%0d", i), i, px(i == 0, (i % 4) == 3, 8'(2 * i)));
    check_val("t2_frame_cnt", 32'(frame_cnt), 32'd1);
    check_val("t2_fmt_err", 32'(fmt_err), 32'd0);

    // FIFO full, pop coincides with the next push
    qb = q.size();
    pix_ready = 1'b0;
    frame_start(1'b1);
    send_line(8'h10, 8);
    check_val("t4_full_valid", 32'(pix_valid), 32'd1);
    cam_href = 1'b1;
    tick();
    cam_valid = 1'b1; cam_data = 8'h18;
    tick();
    cam_data = 8'h19; pix_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      cam_data = 8'(8'h1A + i);
      tick();
    end
    cam_valid = 1'b0; cam_href = 1'b0;
    tick();
    tick();
    frame_end();
    repeat (6) tick();
    check_val("t4_ovf", 32'(ovf), 32'd0);
    check_val("t4_count", 32'(q.size() - qb), 32'd8);
    for (int i = 0; i < 8; i++)
      check_pix($sformatf("t4_pix%0d", i), i, px(i == 0, (i % 4) == 3, 8'(8'h10 + 2 * i)));
    check_val("t4_frame_cnt", 32'(frame_cnt), 32'd2);

    // cap_en low at frame start: frame skipped, next one captured
    qb = q.size();
    frame_start(1'b0);
    cap_en = 1'b1;
    send_line(8'h20, 8);
    send_line(8'h28, 8);
    frame_end();
    check_val("t6_skip_pixels", 32'(q.size() - qb), 32'd0);
    check_val("t6_skip_frame_cnt", 32'(frame_cnt), 32'd2);
    frame_start(1'b1);
    send_line(8'h30, 8);
    send_line(8'h38, 8);
    frame_end();
    repeat (4) tick();
    check_val("t6_count", 32'(q.size() - qb), 32'd8);
    check_pix("t6_first", 0, px(1'b1, 1'b0, 8'h30));
    check_pix("t6_last", 7, px(1'b0, 1'b1, 8'h3E));
    check_val("t6_frame_cnt", 32'(frame_cnt), 32'd3);
    check_val("t6_fmt_err", 32'(fmt_err), 32'd0);

    // Overflow: 6 pixels into a 4-deep FIFO with no reader
    qb = q.size();
    pix_ready = 1'b0;
    frame_start(1'b1);
    send_line(8'h40, 12);
    check_val("t3_valid", 32'(pix_valid), 32'd1);
    check_val("t3_ovf", 32'(ovf), 32'd1);
    check_val("t3_head", 32'({pix_sof, pix_eol, pix_data}), 32'(px(1'b1, 1'b0, 8'h40)));
    repeat (3) tick();
    check_val("t3_head_hold", 32'(pix_data), 32'h4041);
    pix_ready = 1'b1;
    repeat (6) tick();
    check_val("t3_count", 32'(q.size() - qb), 32'd4);
    check_pix("t3_pix0", 0, px(1'b1, 1'b0, 8'h40));
    check_pix("t3_pix1", 1, px(1'b0, 1'b0, 8'h42));
    check_pix("t3_pix2", 2, px(1'b0, 1'b0, 8'h44));
    check_pix("t3_pix3", 3, px(1'b0, 1'b1, 8'h46));
    check_val("t3_drained", 32'(pix_valid), 32'd0);
    frame_end();
    check_val("t3_fmt_err", 32'(fmt_err), 32'd1);
    check_val("t3_frame_cnt", 32'(frame_cnt), 32'd4);

    // Short line with an odd byte, after a reset clears the sticky flags
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check_val("t5_rst_flags", 32'({ovf, fmt_err}), 32'd0);
    check_val("t5_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    qb = q.size();
    frame_start(1'b1);
    send_line(8'h50, 7);
    check_val("t5_fmt_err", 32'(fmt_err), 32'd1);
    send_line(8'h60, 8);
    frame_end();
    repeat (4) tick();
    check_val("t5_count", 32'(q.size() - qb), 32'd7);
    check_pix("t5_first", 0, px(1'b1, 1'b0, 8'h50));
    check_pix("t5_line2_first", 3, px(1'b0, 1'b0, 8'h60));
    check_pix("t5_line2_eol", 6, px(1'b0, 1'b1, 8'h66));
    check_val("t5_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
